// File: rtl/lightbike_pkg.sv
// Shared types and constants for the lightbike round controller.
package lightbike_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_COUNTDOWN = 3'd2,
    ST_PLAY      = 3'd3,
    ST_HOLD      = 3'd4
  } state_t;

  localparam logic [2:0] WIN_NONE  = 3'd0;
  localparam logic [2:0] WIN_BIKE0 = 3'd1;
  localparam logic [2:0] WIN_BIKE1 = 3'd2;
  localparam logic [2:0] WIN_BIKE2 = 3'd3;
  localparam logic [2:0] WIN_BIKE3 = 3'd4;

  localparam logic [3:0] MASK_2P = 4'b0011;
  localparam logic [3:0] MASK_4P = 4'b1111;

endpackage

// File: rtl/tick_timer.sv
// Seconds-by-frame-tick down counter; load is immediate, done is a combinational
// pulse on the tick that takes the seconds count from 1 to 0 (no backpressure).
module tick_timer #(
  parameter int TICKS_PER_SEC = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_secs,
  input  logic       en,
  input  logic       tick,
  output logic [7:0] secs_next,
  output logic       done
);

  localparam logic [15:0] TPS_M1 = 16'(TICKS_PER_SEC - 1);

  logic [7:0]  secs;
  logic [15:0] ticks, ticks_next;
  logic        wrap;

  assign wrap = en && tick && (ticks == TPS_M1);
  assign done = wrap && (secs == 8'd1);

  always_comb begin
    secs_next  = secs;
    ticks_next = ticks;
    if (load) begin
      secs_next  = load_secs;
      ticks_next = '0;
    end else if (wrap) begin
      secs_next  = secs - 8'd1;
      ticks_next = '0;
    end else if (en && tick) begin
      ticks_next = ticks + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      secs  <= '0;
      ticks <= '0;
    end else begin
      secs  <= secs_next;
      ticks <= ticks_next;
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// Lightbike round controller: clear -> countdown -> play -> hold, with scoring.
// All outputs registered; crash to run-low in one edge, start edge to CLEAR in two.
module round_sequencer
  import lightbike_pkg::*;
#(
  parameter int TICKS_PER_SEC = 60,
  parameter int COUNT_SECS    = 3,
  parameter int HOLD_SECS     = 2,
  parameter int WIN_SCORE     = 5,
  parameter int CLEAR_CYCLES  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        four_player_mode,
  input  logic [3:0]  crash,
  output logic        run,
  output logic        clear_map,
  output logic [1:0]  countdown,
  output logic [3:0]  alive,
  output logic [2:0]  winner,
  output logic [15:0] scores,
  output logic        match_over,
  output logic [2:0]  state
);

  localparam logic [15:0] CLR_M1 = 16'(CLEAR_CYCLES - 1);
  localparam logic [3:0]  WIN_S  = 4'(WIN_SCORE);

  state_t      st_q, st_d;
  logic [15:0] clr_cnt, clr_cnt_d;
  logic [3:0]  alive_d, alive_play, round_mask;
  logic [2:0]  winner_d, win_code, pop;
  logic [15:0] scores_d;
  logic        match_d, score_hit;
  logic        start_q, armed, start_rise;
  logic        tmr_load, tmr_done;
  logic [7:0]  tmr_secs, secs_next;

  assign state      = st_q;
  assign alive_play = alive & ~crash;
  assign round_mask = four_player_mode ? MASK_4P : MASK_2P;
  assign pop = {2'b0, alive_play[0]} + {2'b0, alive_play[1]}
             + {2'b0, alive_play[2]} + {2'b0, alive_play[3]};

  always_comb begin
    win_code  = WIN_NONE;
    score_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (alive_play == (4'b0001 << i)) win_code = 3'(i + 1);
      if (scores[4*i +: 4] >= WIN_S) score_hit = 1'b1;
    end
  end

  tick_timer #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (tmr_load),
    .load_secs (tmr_secs),
    .en        ((st_q == ST_COUNTDOWN) || (st_q == ST_HOLD)),
    .tick      (frame_tick),
    .secs_next (secs_next),
    .done      (tmr_done)
  );

  always_comb begin
    st_d      = st_q;
    clr_cnt_d = clr_cnt;
    alive_d   = alive;
    winner_d  = winner;
    scores_d  = scores;
    match_d   = match_over;
    tmr_load  = 1'b0;
    tmr_secs  = 8'(COUNT_SECS);
    case (st_q)
      ST_IDLE: if (start_rise) begin
        st_d      = ST_CLEAR;
        clr_cnt_d = '0;
        alive_d   = round_mask;
        winner_d  = WIN_NONE;
        scores_d  = '0;
        match_d   = 1'b0;
      end
      ST_CLEAR: if (clr_cnt == CLR_M1) begin
        st_d     = ST_COUNTDOWN;
        tmr_load = 1'b1;
      end else begin
        clr_cnt_d = clr_cnt + 16'd1;
      end
      ST_COUNTDOWN: if (tmr_done) st_d = ST_PLAY;
      ST_PLAY: begin
        alive_d = alive_play;
        if (pop <= 3'd1) begin
          st_d     = ST_HOLD;
          winner_d = win_code;
          tmr_load = 1'b1;
          tmr_secs = 8'(HOLD_SECS);
          // Score saturates at 15; a draw (WIN_NONE) matches no bike.
          for (int i = 0; i < 4; i++)
            if (win_code == 3'(i + 1) && scores[4*i +: 4] != 4'hF)
              scores_d[4*i +: 4] = scores[4*i +: 4] + 4'd1;
        end
      end
      ST_HOLD: if (tmr_done) begin
        if (score_hit) begin
          st_d    = ST_IDLE;
          match_d = 1'b1;
        end else begin
          st_d      = ST_CLEAR;
          clr_cnt_d = '0;
          alive_d   = round_mask;
          winner_d  = WIN_NONE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q       <= ST_IDLE;
      clr_cnt    <= '0;
      alive      <= '0;
      winner     <= WIN_NONE;
      scores     <= '0;
      match_over <= 1'b0;
      run        <= 1'b0;
      clear_map  <= 1'b0;
      countdown  <= '0;
      start_q    <= 1'b0;
      armed      <= 1'b0;
      start_rise <= 1'b0;
    end else begin
      st_q       <= st_d;
      clr_cnt    <= clr_cnt_d;
      alive      <= alive_d;
      winner     <= winner_d;
      scores     <= scores_d;
      match_over <= match_d;
      run        <= (st_d == ST_PLAY);
      clear_map  <= (st_d == ST_CLEAR);
      countdown  <= (st_d == ST_COUNTDOWN) ? 2'(secs_next) : 2'd0;
      // A start held high through reset must be seen low before it can arm.
      start_q    <= start;
      armed      <= armed | ~start;
      start_rise <= start & ~start_q & armed;
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed scoreboard bench for round_sequencer using small timing parameters.
module tb_round_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        four_player_mode = 1'b0;
  logic [3:0]  crash = 4'h0;
  logic        run, clear_map, match_over;
  logic [1:0]  countdown;
  logic [3:0]  alive;
  logic [2:0]  winner, state;
  logic [15:0] scores;

  round_sequencer #(
    .TICKS_PER_SEC(2), .COUNT_SECS(3), .HOLD_SECS(1), .WIN_SCORE(2), .CLEAR_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .start(start),
    .four_player_mode(four_player_mode), .crash(crash), .run(run),
    .clear_map(clear_map), .countdown(countdown), .alive(alive), .winner(winner),
    .scores(scores), .match_over(match_over), .state(state)
  );

  always #5 clock = ~clock;

  localparam int F_RUN = 0, F_CLR = 1, F_CD = 2, F_ALIVE = 3;
  localparam int F_WIN = 4, F_SCORES = 5, F_MATCH = 6, F_STATE = 7;

  typedef struct {
    int          cyc;
    int          fld;
    logic [15:0] val;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   next_id = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic string fname(input int f);
    case (f)
      F_RUN:    return "run";
      F_CLR:    return "clear_map";
      F_CD:     return "countdown";
      F_ALIVE:  return "alive";
      F_WIN:    return "winner";
      F_SCORES: return "scores";
      F_MATCH:  return "match_over";
      default:  return "state";
    endcase
  endfunction

  function automatic logic [15:0] dut_val(input int f);
    case (f)
      F_RUN:    return 16'(run);
      F_CLR:    return 16'(clear_map);
      F_CD:     return 16'(countdown);
      F_ALIVE:  return 16'(alive);
      F_WIN:    return 16'(winner);
      F_SCORES: return scores;
      F_MATCH:  return 16'(match_over);
      default:  return 16'(state);
    endcase
  endfunction

  // Monitor: the DUT presents its registered outputs every cycle; compare them
  // mid-cycle against whatever the stimulus queued for this cycle.
  always @(negedge clock) begin
    exp_t e;
    logic [15:0] got;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e   = exp_q.pop_front();
      got = dut_val(e.fld);
      n_checks++;
      if (got !== e.val) begin
        n_fail++;
        $display("FAIL check#%0d %s: got %h expected %h (cycle %0d)",
                 e.id, fname(e.fld), got, e.val, cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic chk(input int f, input logic [15:0] v);
    exp_t e;
    e.cyc = cyc;
    e.fld = f;
    e.val = v;
    e.id  = next_id;
    next_id++;
    exp_q.push_back(e);
  endtask

  task automatic pulse_crash(input logic [3:0] c);
    crash = c;
    step(1);
    crash = 4'h0;
  endtask

  // From the first CLEAR cycle: 4 clear cycles, then 6 countdown ticks.
  task automatic to_play();
    step(3);
    step(1);
    repeat (6) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values
    reset = 1'b1;
    step(3);
    chk(F_RUN, 0); chk(F_CLR, 0); chk(F_CD, 0); chk(F_ALIVE, 0);
    chk(F_WIN, 0); chk(F_SCORES, 0); chk(F_MATCH, 0); chk(F_STATE, 0);
    reset = 1'b0;
    crash = 4'hF;
    step(2);
    chk(F_STATE, 0); chk(F_ALIVE, 0); chk(F_RUN, 0);
    crash = 4'h0;

    // Two-player round, detailed timing
    four_player_mode = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk(F_STATE, 0); chk(F_CLR, 0);
    step(1);
    chk(F_STATE, 1); chk(F_CLR, 1); chk(F_ALIVE, 16'h3); chk(F_SCORES, 0);
    step(3);
    chk(F_CLR, 1); chk(F_STATE, 1);
    step(1);
    chk(F_STATE, 2); chk(F_CLR, 0); chk(F_CD, 3);
    tick();  chk(F_CD, 3);
    step(2); chk(F_CD, 3);
    tick();  chk(F_CD, 2);
    tick(); tick(); chk(F_CD, 1);
    tick();  chk(F_STATE, 2); chk(F_RUN, 0);
    tick();  chk(F_STATE, 3); chk(F_RUN, 1); chk(F_CD, 0);

    // Ignored start / mode / masked crash during PLAY
    start = 1'b1; step(1); start = 1'b0; step(1);
    start = 1'b1; step(1); start = 1'b0;
    four_player_mode = 1'b1;
    step(2);
    chk(F_STATE, 3); chk(F_ALIVE, 16'h3);
    pulse_crash(4'b1000);
    chk(F_STATE, 3); chk(F_ALIVE, 16'h3); chk(F_RUN, 1);
    pulse_crash(4'b0010);
    chk(F_RUN, 0); chk(F_WIN, 1); chk(F_SCORES, 16'h0001); chk(F_STATE, 4); chk(F_ALIVE, 16'h1);
    tick(); chk(F_STATE, 4);
    tick();
    chk(F_STATE, 1); chk(F_WIN, 0); chk(F_ALIVE, 16'hF); chk(F_CLR, 1); chk(F_SCORES, 16'h0001);

    // Four-player draw
    to_play();
    chk(F_RUN, 1); chk(F_ALIVE, 16'hF);
    pulse_crash(4'b0001); chk(F_ALIVE, 16'hE); chk(F_STATE, 3);
    pulse_crash(4'b0010); chk(F_ALIVE, 16'hC);
    pulse_crash(4'b1100);
    chk(F_STATE, 4); chk(F_WIN, 0); chk(F_SCORES, 16'h0001); chk(F_ALIVE, 0); chk(F_RUN, 0);
    tick(); tick();
    chk(F_STATE, 1);

    // Bike 2 wins twice: match ends
    to_play();
    pulse_crash(4'b1011);
    chk(F_WIN, 3); chk(F_SCORES, 16'h0101); chk(F_STATE, 4);
    tick(); tick();
    chk(F_STATE, 1); chk(F_MATCH, 0);
    to_play();
    pulse_crash(4'b1011);
    chk(F_WIN, 3); chk(F_SCORES, 16'h0201);
    tick(); chk(F_STATE, 4); chk(F_MATCH, 0);
    tick();
    chk(F_STATE, 0); chk(F_MATCH, 1); chk(F_SCORES, 16'h0201); chk(F_RUN, 0); chk(F_CLR, 0);
    step(2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk(F_SCORES, 16'h0201);
    step(1);
    chk(F_STATE, 1); chk(F_SCORES, 0); chk(F_MATCH, 0); chk(F_WIN, 0);

    // Bike 3 wins, then reset in the middle of the next PLAY
    to_play();
    pulse_crash(4'b0111);
    chk(F_WIN, 4); chk(F_SCORES, 16'h1000);
    tick(); tick();
    chk(F_STATE, 1);
    to_play();
    chk(F_RUN, 1);
    reset = 1'b1;
    step(1);
    chk(F_RUN, 0); chk(F_SCORES, 0); chk(F_STATE, 0); chk(F_ALIVE, 0); chk(F_WIN, 0);

    // Start held high through reset must not begin a round
    start = 1'b1;
    step(2);
    reset = 1'b0;
    step(3);
    chk(F_STATE, 0);
    start = 1'b0; step(1);
    start = 1'b1; step(1);
    start = 1'b0; step(1);
    chk(F_STATE, 1);

    step(1);
    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
